// File: rtl/stream_upsizer_pkg.sv
// Shared helpers for the stream width converters: lane slicing and count-width sizing.
package stream_upsizer_pkg;

    // Low bit of lane k when lanes are dw bits wide.
    function automatic int unsigned lane_lo(input int unsigned k, input int unsigned dw);
        return k * dw;
    endfunction

    // Width needed to hold a lane count in 0..scale.
    function automatic int unsigned count_width(input int unsigned scale);
        return $clog2(scale + 1);
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Registered output stage of the upsizer: holds one packed word plus its valid/ready bookkeeping.
module stream_out_reg #(
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic          last_i,
    input  logic [CW-1:0] count_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          last_o,
    output logic [CW-1:0] count_o
);

    logic          full_q, full_d;
    logic [DW-1:0] data_q, data_d;
    logic          last_q, last_d;
    logic [CW-1:0] count_q, count_d;

    // A load wins over a drain in the same cycle, so back-to-back words never bubble.
    always_comb begin
        full_d  = full_q;
        data_d  = data_q;
        last_d  = last_q;
        count_d = count_q;
        if (load_i) begin
            full_d  = 1'b1;
            data_d  = data_i;
            last_d  = last_i;
            count_d = count_i;
        end else if (full_q && ready_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q  <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            count_q <= '0;
        end else begin
            full_q  <= full_d;
            data_q  <= data_d;
            last_q  <= last_d;
            count_q <= count_d;
        end
    end

    assign valid_o = full_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
    assign count_o = count_q;

endmodule

// File: rtl/stream_upsizer.sv
// Packs SCALE narrow input beats into one wide output word; s_last_i closes a word early.
module stream_upsizer
    import stream_upsizer_pkg::*;
#(
    parameter int unsigned DW_IN = 8,
    parameter int unsigned SCALE = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DW_IN-1:0]                    s_data_i,
    input  logic                                s_valid_i,
    input  logic                                s_last_i,
    output logic                                s_ready_o,
    output logic [DW_IN*SCALE-1:0]              m_data_o,
    output logic                                m_valid_o,
    output logic                                m_last_o,
    output logic [count_width(SCALE)-1:0]       m_count_o,
    input  logic                                m_ready_i
);

    localparam int unsigned DW_OUT = DW_IN * SCALE;
    localparam int unsigned IW     = $clog2(SCALE);
    localparam int unsigned CW     = count_width(SCALE);

    logic [DW_OUT-1:0] acc_q, acc_d;
    logic [DW_OUT-1:0] word;
    logic [IW-1:0]     idx_q, idx_d;
    logic              rst_r_q;
    logic              out_full;
    logic              wr;
    logic              complete;
    logic [CW-1:0]     word_count;

    // Ready depends only on state and m_ready_i, never on the incoming beat.
    assign s_ready_o  = !rst_r_q && (!out_full || m_ready_i);
    assign wr         = s_valid_i && s_ready_o;
    assign complete   = wr && ((idx_q == IW'(SCALE - 1)) || s_last_i);
    assign word_count = CW'(idx_q) + CW'(1);

    always_comb begin
        word  = '0;
        acc_d = acc_q;
        idx_d = idx_q;
        // Lanes above the current index stay zero on a short word.
        for (int unsigned k = 0; k < SCALE; k++) begin
            if (IW'(k) < idx_q) begin
                word[lane_lo(k, DW_IN) +: DW_IN] = acc_q[lane_lo(k, DW_IN) +: DW_IN];
            end else if (IW'(k) == idx_q) begin
                word[lane_lo(k, DW_IN) +: DW_IN] = s_data_i;
            end
        end
        if (complete) begin
            acc_d = '0;
            idx_d = '0;
        end else if (wr) begin
            acc_d[lane_lo(32'(idx_q), DW_IN) +: DW_IN] = s_data_i;
            idx_d = idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            idx_q   <= '0;
            rst_r_q <= 1'b1;
        end else begin
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            rst_r_q <= 1'b0;
        end
    end

    stream_out_reg #(
        .DW (DW_OUT),
        .CW (CW)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (complete),
        .data_i  (word),
        .last_i  (s_last_i),
        .count_i (word_count),
        .ready_i (m_ready_i),
        .valid_o (out_full),
        .data_o  (m_data_o),
        .last_o  (m_last_o),
        .count_o (m_count_o)
    );

    assign m_valid_o = out_full;

endmodule

// File: tb/tb_stream_upsizer.sv
// Randomised scoreboard bench for stream_upsizer with directed packing, backpressure and reset cases.
module tb_stream_upsizer;

    localparam int unsigned DW_IN  = 8;
    localparam int unsigned SCALE  = 4;
    localparam int unsigned DW_OUT = DW_IN * SCALE;
    localparam int unsigned CW     = $clog2(SCALE + 1);

    typedef struct {
        logic [DW_OUT-1:0] data;
        int unsigned       count;
        bit                last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DW_IN-1:0]  s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_last = 1'b0;
    logic              s_ready_o;
    logic [DW_OUT-1:0] m_data_o;
    logic              m_valid_o;
    logic              m_last_o;
    logic [CW-1:0]     m_count_o;
    logic              m_ready = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int unsigned accepted = 0;
    int unsigned stalls = 0;
    int unsigned words_seen = 0;
    int unsigned words_exp = 0;
    int          mode = 1;

    logic [DW_IN-1:0] partial[$];
    exp_t             exp_q[$];

    stream_upsizer #(
        .DW_IN (DW_IN),
        .SCALE (SCALE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data_i  (s_data),
        .s_valid_i (s_valid),
        .s_last_i  (s_last),
        .s_ready_o (s_ready_o),
        .m_data_o  (m_data_o),
        .m_valid_o (m_valid_o),
        .m_last_o  (m_last_o),
        .m_count_o (m_count_o),
        .m_ready_i (m_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Reference: collect beats; a word is SCALE beats or ends at a last beat, lane 0 first.
    task automatic model_beat(input logic [DW_IN-1:0] d, input bit l);
        exp_t e;
        partial.push_back(d);
        if (partial.size() == SCALE || l) begin
            e.data = '0;
            foreach (partial[i]) e.data = e.data | (DW_OUT'(partial[i]) << (DW_IN * i));
            e.count = partial.size();
            e.last  = l;
            exp_q.push_back(e);
            words_exp++;
            partial.delete();
        end
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send(input logic [DW_IN-1:0] d, input bit l);
        int waited = 0;
        bit done = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!done) begin
            @(negedge clk);
            if (s_ready_o) begin
                model_beat(d, l);
                accepted++;
                done = 1;
            end else begin
                stalls++;
                waited++;
                if (waited > 100) begin
                    check("send_timeout", 64'(waited), 64'd0);
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: pops the scoreboard on every output handshake and checks held words stay put.
    bit                hold = 0;
    logic [DW_OUT-1:0] hold_data;
    logic              hold_last;
    logic [CW-1:0]     hold_count;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold = 0;
        end else begin
            if (hold) begin
                check("held_word_stable", {m_valid_o, m_last_o, m_count_o, m_data_o},
                      {1'b1, hold_last, hold_count, hold_data});
            end
            if (m_valid_o && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(m_data_o), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", 64'(m_data_o), 64'(e.data));
                    check("word_count", 64'(m_count_o), 64'(e.count));
                    check("word_last", 64'(m_last_o), 64'(e.last));
                end
                words_seen++;
            end
            hold       = m_valid_o && !m_ready;
            hold_data  = m_data_o;
            hold_last  = m_last_o;
            hold_count = m_count_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned s0;
        int unsigned w0;
        int unsigned base;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_m_valid", 64'(m_valid_o), 64'd0);
        check("reset_s_ready", 64'(s_ready_o), 64'd0);
        check("reset_m_data", 64'(m_data_o), 64'd0);
        check("reset_m_count", 64'(m_count_o), 64'd0);
        check("reset_m_last", 64'(m_last_o), 64'd0);
        @(posedge clk);
        #1;
        check("ready_after_reset", 64'(s_ready_o), 64'd1);

        // Full word on consecutive beats.
        s0 = stalls;
        send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
        check("t1_valid_next_cycle", 64'(m_valid_o), 64'd1);
        check("t1_data", 64'(m_data_o), 64'h4433_2211);
        check("t1_count", 64'(m_count_o), 64'd4);
        check("t1_no_stall", 64'(stalls - s0), 64'd0);

        // Early termination, then a single-beat word starting again at lane 0.
        send(8'hAA, 0); send(8'hBB, 1);
        check("t2_data", 64'(m_data_o), 64'h0000_BBAA);
        check("t2_count", 64'(m_count_o), 64'd2);
        check("t2_last", 64'(m_last_o), 64'd1);
        send(8'h5C, 1);
        check("t3_data", 64'(m_data_o), 64'h0000_005C);
        check("t3_count_last", 64'({m_count_o, m_last_o}), 64'({3'd1, 1'b1}));
        idle(2);

        // Backpressure: downstream stalls, first word held, then released.
        mode = 0;
        idle(2);
        base = accepted;
        fork
            begin
                for (int i = 1; i <= 8; i++) send(8'(i), 0);
                s_valid = 1'b0;
            end
            begin
                repeat (15) @(negedge clk);
                check("t4_accepted_while_blocked", 64'(accepted - base), 64'd4);
                check("t4_s_ready_low", 64'(s_ready_o), 64'd0);
                check("t4_m_valid", 64'(m_valid_o), 64'd1);
                check("t4_held_data", 64'(m_data_o), 64'h0403_0201);
                mode = 1;
            end
        join
        idle(3);
        check("t4_accepted_total", 64'(accepted - base), 64'd8);

        // Continuous stream with simultaneous load and drain.
        s0 = stalls;
        w0 = words_seen;
        for (int i = 0; i < 12; i++) send(8'($urandom), 0);
        idle(3);
        check("t5_no_stall", 64'(stalls - s0), 64'd0);
        check("t5_words", 64'(words_seen - w0), 64'd3);

        // Reset mid-word discards the partial word.
        send(8'h11, 0); send(8'h22, 0);
        s_valid = 1'b0;
        rst = 1'b1;
        partial.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t6_s_ready_in_reset", 64'(s_ready_o), 64'd0);
        check("t6_m_valid_in_reset", 64'(m_valid_o), 64'd0);
        @(posedge clk);
        #1;
        check("t6_s_ready_after", 64'(s_ready_o), 64'd1);
        w0 = words_seen;
        send(8'h33, 0); send(8'h44, 0); send(8'h55, 0); send(8'h66, 0);
        idle(3);
        check("t6_words", 64'(words_seen - w0), 64'd1);

        // Random traffic with random backpressure and idle cycles carrying stray s_last.
        mode = 2;
        repeat (200) begin
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                s_data  = 8'($urandom);
                s_last  = ($urandom_range(0, 1) == 1);
                @(posedge clk);
                #1;
            end else begin
                send(8'($urandom), ($urandom_range(0, 4) == 0));
            end
        end
        send(8'hEE, 1);
        mode = 1;
        idle(10);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
